// File: rtl/arb_pkg.sv
// Shared definitions for the ten-way round-robin arbiter.
// Requester count, index width, FSM state encoding and the
// hold-counter width helper used when ARB_TIMEOUT_EN is defined.
package arb_pkg;

   localparam int NREQ  = 10;
   localparam int IDX_W = 4;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // Width of a counter able to reach max_hold.
   function automatic int hold_cnt_w(input int max_hold);
      return $clog2(max_hold + 1);
   endfunction

endpackage

// File: rtl/rr_pick10.sv
// Combinational rotate-and-priority selector for ten requesters.
// Search order is ptr+1, ptr+2, ... wrapping 9 -> 0 and ending at ptr,
// so the previous winner always has the lowest priority.
module rr_pick10
   import arb_pkg::*;
(
   input  logic [NREQ-1:0]  i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_win,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [IDX_W:0] w_pos;

   // Walk the candidates in round-robin order; the first requester seen wins.
   always_comb begin
      o_win = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_pos = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_pos = {1'b0, i_ptr} + (IDX_W+1)'(1) + (IDX_W+1)'(k);
         // ptr never exceeds 9, so a single subtraction is enough to wrap.
         if (w_pos >= (IDX_W+1)'(NREQ)) begin
            w_pos = w_pos - (IDX_W+1)'(NREQ);
         end
         if (!o_any && i_req[w_pos[IDX_W-1:0]]) begin
            o_any                     = 1'b1;
            o_win[w_pos[IDX_W-1:0]]   = 1'b1;
            o_idx                     = w_pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_10.sv
// Round-robin arbiter for ten requesters with one-hot grant and index.
// Grants are held until the owner drops its request; every grant is
// followed by at least one idle cycle before the next arbitration.
// Optional feature macro: ARB_TIMEOUT_EN adds a forced release after
// MAX_HOLD grant cycles, signalled by a one-cycle timeout pulse.
module rr_arbiter_10 #(
   parameter int NREQ     = 10,
   parameter int MAX_HOLD = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   output logic [NREQ-1:0]          gnt,
   output logic [arb_pkg::IDX_W-1:0] gnt_idx,
   output logic                     gnt_valid,
   output logic                     timeout,
   output arb_pkg::arb_state_e      o_dbg_state
);

   import arb_pkg::*;

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_arbiter_10: MAX_HOLD must be within 1..255");
   end

   arb_state_e       r_state, w_state_nxt;
   logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt;
   logic             r_valid, w_valid_nxt;
   logic [IDX_W-1:0] r_ptr, w_ptr_nxt;

   logic [NREQ-1:0]  w_win;
   logic [IDX_W-1:0] w_win_idx;
   logic             w_any;
   logic             w_owner_req;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = hold_cnt_w(MAX_HOLD);
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_timeout, w_timeout_nxt;
   logic             w_hold_hit;
   // Counter value in the last allowed grant cycle (counter starts at 0).
   assign w_hold_hit = (r_cnt == CNT_W'(MAX_HOLD - 1));
`endif

   rr_pick10 u_pick (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_win (w_win),
      .o_idx (w_win_idx),
      .o_any (w_any)
   );

   assign w_owner_req = req[r_idx];

   // State and registered grant outputs; reset clears a grant in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ARB_IDLE;
         r_gnt   <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_ptr   <= IDX_W'(NREQ - 1);
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_idx   <= w_idx_nxt;
         r_valid <= w_valid_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Hold counter and timeout pulse register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end
`endif

   // Next-state logic: arbitrate in IDLE, hold or release in BUSY.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_idx_nxt   = r_idx;
      w_valid_nxt = r_valid;
      w_ptr_nxt   = r_ptr;
`ifdef ARB_TIMEOUT_EN
      w_cnt_nxt     = r_cnt;
      w_timeout_nxt = 1'b0;
`endif
      case (r_state)
         ARB_IDLE: begin
            if (w_any) begin
               w_state_nxt = ARB_BUSY;
               w_gnt_nxt   = w_win;
               w_idx_nxt   = w_win_idx;
               w_valid_nxt = 1'b1;
               w_ptr_nxt   = w_win_idx;
`ifdef ARB_TIMEOUT_EN
               w_cnt_nxt   = '0;
`endif
            end
         end
         ARB_BUSY: begin
            // A normal release takes precedence over a coincident timeout.
            if (!w_owner_req) begin
               w_state_nxt = ARB_IDLE;
               w_gnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_valid_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
            end else if (w_hold_hit) begin
               w_state_nxt   = ARB_IDLE;
               w_gnt_nxt     = '0;
               w_idx_nxt     = '0;
               w_valid_nxt   = 1'b0;
               w_timeout_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
            w_gnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   // Outputs come straight from registers; no path from req.
   always_comb begin
      gnt         = r_gnt;
      gnt_idx     = r_idx;
      gnt_valid   = r_valid;
      o_dbg_state = r_state;
`ifdef ARB_TIMEOUT_EN
      timeout     = r_timeout;
`else
      timeout     = 1'b0;
`endif
   end

endmodule

// File: tb/tb_rr_arbiter_10.sv
// Directed bench for rr_arbiter_10: reset, single owner, fairness with
// wrap, same-edge handover, hold timeout (ARB_TIMEOUT_EN) and mid-grant reset.
module tb_rr_arbiter_10;
  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] req;
  logic [9:0] gnt;
  logic [3:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  arb_state_e dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  rr_arbiter_10 #(.NREQ(10), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .timeout     (timeout),
    .o_dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] e_gnt, input logic [3:0] e_idx,
                     input logic e_valid, input logic e_to);
    n_assert++;
    assert (gnt === e_gnt) else begin
      n_fail++;
      $error("FAIL %s gnt got %b exp %b", tag, gnt, e_gnt);
    end
    n_assert++;
    assert (gnt_idx === e_idx) else begin
      n_fail++;
      $error("FAIL %s gnt_idx got %0d exp %0d", tag, gnt_idx, e_idx);
    end
    n_assert++;
    assert (gnt_valid === e_valid) else begin
      n_fail++;
      $error("FAIL %s gnt_valid got %b exp %b", tag, gnt_valid, e_valid);
    end
    n_assert++;
    assert (timeout === e_to) else begin
      n_fail++;
      $error("FAIL %s timeout got %b exp %b", tag, timeout, e_to);
    end
  endtask

  task automatic chk_grant(input string tag, input int who);
    logic [9:0] oh;
    oh = 10'b1 << who;
    chk(tag, oh, 4'(who), 1'b1, 1'b0);
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 10'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int fair_order [6];
    fair_order = '{0, 3, 9, 0, 3, 9};

    // Reset with every requester active.
    rst = 1'b1;
    req = 10'h3FF;
    tick(); chk_idle("rst_c1");
    tick(); chk_idle("rst_c2");
    rst = 1'b0;
    tick(); chk_grant("first_grant", 0);
    req = 10'h000;
    tick(); chk_idle("first_release");
    tick(); chk_idle("first_gap");

    // Single requester 7 held for 5 cycles.
    req = 10'h080;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_grant("single_7_hold", 7);
    end
    req = 10'h000;
    tick(); chk_idle("single_7_release");
    tick(); chk_idle("single_7_gap");

    // Fairness: reset ptr to 9, then 0/3/9 compete with brief drops.
    rst = 1'b1;
    tick(); chk_idle("fair_rst");
    rst = 1'b0;
    req = 10'h209;
    for (int i = 0; i < 6; i++) begin
      tick(); chk_grant("fair_c1", fair_order[i]);
      tick(); chk_grant("fair_c2", fair_order[i]);
      req = 10'h209 & ~(10'b1 << fair_order[i]);
      tick(); chk_idle("fair_drop");
      req = 10'h209;
    end
    req = 10'h000;
    tick(); chk_idle("fair_end");

    // Same-edge release of 2 and rise of 5.
    req = 10'h004;
    tick(); chk_grant("handover_2_c1", 2);
    tick(); chk_grant("handover_2_c2", 2);
    req = 10'h020;
    tick(); chk_idle("handover_gap");
    tick(); chk_grant("handover_5", 5);
    req = 10'h000;
    tick(); chk_idle("handover_release");

    // Requesters 1 and 4 held; ptr is 5 so requester 1 wins.
    req = 10'h012;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_grant("hold_1", 1);
    end
`ifdef ARB_TIMEOUT_EN
    tick(); chk("timeout_pulse", 10'b0, 4'd0, 1'b0, 1'b1);
    tick(); chk_grant("after_timeout_4", 4);
`else
    for (int i = 0; i < 3; i++) begin
      tick(); chk_grant("no_timeout_hold_1", 1);
    end
`endif
    req = 10'h000;
    tick(); chk_idle("hold_release");
    tick(); chk_idle("hold_gap");

    // Release in the last allowed cycle: no timeout pulse.
    req = 10'h008;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_grant("edge_hold_3", 3);
    end
    req = 10'h000;
    tick(); chk_idle("edge_release_no_to");
    tick(); chk_idle("edge_gap");

    // Reset during the 3rd cycle of a grant to 6; ptr must be back at 9.
    req = 10'h040;
    tick(); chk_grant("mid_6_c1", 6);
    tick(); chk_grant("mid_6_c2", 6);
    tick(); chk_grant("mid_6_c3", 6);
    rst = 1'b1;
    req = 10'h141;
    tick(); chk_idle("mid_rst_clear");
    rst = 1'b0;
    tick(); chk_grant("after_rst_ptr9", 0);
    req = 10'h000;
    tick(); chk_idle("final_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_10.md
# rr_arbiter_10

Round-robin arbiter sharing one resource among ten requesters, producing a one-hot grant plus its 4-bit binary index (bit i → index i, same mapping as the team's 10-to-4 encoder). It sits in front of any shared datapath that needs the winner as an index. Grants are held until the owner releases its request; an optional hold-timeout forcibly reclaims the resource from a stuck owner.

## Interface
- `NREQ`, default 10. Number of requesters; fixed at 10 for this block.
- `MAX_HOLD`, default 16. Maximum grant length in cycles when the timeout is compiled in; legal range 1..255.
- `clk` input, 1 bit. Single clock; all logic on the rising edge.
- `rst` input, 1 bit. Synchronous, active-high reset.
- `req` input, 10 bits. Level request per requester.
- `gnt` output, 10 bits. One-hot grant; all-zero when no grant.
- `gnt_idx` output, 4 bits. Binary index of the granted requester, 0..9; 0 when `gnt_valid` = 0.
- `gnt_valid` output, 1 bit. High exactly when `gnt` is nonzero.
- `timeout` output, 1 bit. One-cycle pulse on forced release; constant 0 without `ARB_TIMEOUT_EN`.

## Operation
- Two states: `IDLE` and `BUSY`.
- `IDLE`:
  - If `req` ≠ 0, select the winner by search order `ptr+1, ptr+2, …` with wrap 9→0, ending at `ptr`.
  - Register `gnt`, `gnt_idx` and `gnt_valid`; set `ptr` = winner; go to `BUSY`.
  - If `req` = 0, stay in `IDLE`.
- `BUSY`:
  - The grant is held while `req[gnt_idx]` = 1.
  - When `req[gnt_idx]` is sampled 0, clear the grant and go to `IDLE`.
  - Other requests rising or falling in `BUSY` have no effect.
- Round-robin pointer `ptr` (4 bits) resets to 9, so requester 0 has first priority after reset.
- `ptr` updates only when a grant is issued, never on release.
- Arithmetic:
  - Index wrap is explicit: 9 + 1 → 0.
  - Values 10..15 are never produced on `gnt_idx` or `ptr`.
- Reset mid-operation:
  - `rst` sampled high clears everything in the same edge regardless of state, including a grant in progress.
  - `ptr` returns to 9.
- Reset values: `gnt` = 0, `gnt_idx` = 0, `gnt_valid` = 0, `timeout` = 0, state `IDLE`, hold counter 0.

## Timing
- Grant latency: `req` sampled in `IDLE` at edge *t* → `gnt` high after edge *t* (visible in cycle *t+1*).
- Release latency: owner's `req` sampled low at edge *t* → `gnt` low after edge *t*.
- Re-arbitration happens at the earliest at edge *t+1*. There is always a minimum one-cycle `gnt_valid` = 0 gap between consecutive grants, including back-to-back grants to different requesters.
- An owner releasing and re-requesting in consecutive cycles competes normally. Round-robin places it last.
- All outputs are registered; there is no combinational path from `req` to any output.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- When defined:
  - A hold counter clears on grant and increments each `BUSY` cycle.
  - If the owner still requests when the grant has been high for `MAX_HOLD` cycles, the next edge clears the grant, pulses `timeout` for one cycle, and goes to `IDLE`.
  - If release and timeout occur in the same cycle, it is treated as a normal release with `timeout` = 0.
  - The forced-off owner is ordinary for the next arbitration and lowest priority by round-robin.
- When undefined: no counter is instantiated, `timeout` is tied to 0, and grants are held indefinitely.

## Structure
- Shared package `arb_pkg` holds:
  - `NREQ` = 10 and `IDX_W` = 4.
  - The state enum `{ARB_IDLE, ARB_BUSY}`.
  - The hold-counter width function (`$clog2(MAX_HOLD+1)`).
- Sub-module `rr_pick10`: combinational rotate-and-priority selector. Inputs are `req` and `ptr`; outputs are the one-hot winner, its 4-bit index and `any`. It keeps the wrap logic out of the FSM.

## Test plan
- Reset: `rst` = 1 for 2 cycles with `req` = 10'h3FF → all outputs 0. After release, the first grant is `gnt` = 10'b0000000001, `gnt_idx` = 0, one cycle after `req` is sampled.
- Single requester: `req[7]` held 5 cycles, then dropped → `gnt[7]` high for 5 cycles and `gnt_idx` = 7. Grant clears the cycle after the drop, followed by one idle cycle.
- Fairness and wrap:
  - Requesters 0, 3 and 9 are held continuously. Each owner drops for one cycle after 2 grant cycles, then re-requests.
  - Required grant order is 0, 3, 9, 0, 3, 9, with `gnt_idx` equal to 0, 3, 9 in turn.
- Same-edge release and new request: the owner (`req[2]`) drops on the same edge that `req[5]` rises → `gnt` = 0 for one cycle, then `gnt_idx` = 5.
- Timeout, with `ARB_TIMEOUT_EN` and `MAX_HOLD` = 4:
  - `req[1]` and `req[4]` are held high. The sequence is `gnt[1]` for 4 cycles, then `timeout` = 1 for one cycle, then `gnt[4]`.
  - Without the macro, `gnt[1]` is held indefinitely and `timeout` stays 0.
- Reset mid-grant: assert `rst` during the 3rd cycle of a `gnt[6]` grant → outputs clear at the next edge. With `req[6]` and `req[0]` high afterwards, the next grant goes to 0 because `ptr` is back at 9.
